// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with snapshot/restore for branch prediction
module ras_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop_valid,
  input  logic              restore_valid,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic [PTR_W:0]    restore_cnt,
  input  logic [ADDR_W-1:0] restore_data,
  output logic              top_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [PTR_W:0]    ckpt_cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  // Priority chain: flush beats restore beats push/pop; losers leave no trace.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = push_addr;
    if (flush) begin
      tos_d = '0;
      cnt_d = '0;
    end else if (restore_valid) begin
      tos_d   = restore_ptr;
      cnt_d   = (restore_cnt > FULL_CNT) ? FULL_CNT : restore_cnt;
      wr_en   = 1'b1;
      wr_idx  = restore_ptr;
      wr_data = restore_data;
    end else if (push_valid && pop_valid) begin
      // Return-then-call replaces the top in place.
      wr_en = 1'b1;
      cnt_d = (cnt_q == '0) ? (PTR_W+1)'(1) : cnt_q;
    end else if (push_valid) begin
      tos_d  = tos_q + 1'b1;
      wr_en  = 1'b1;
      wr_idx = tos_q + 1'b1;
      if (cnt_q == FULL_CNT) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + 1'b1;
    end else if (pop_valid) begin
      if (cnt_q != '0) begin
        tos_d = tos_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) mem_q[wr_idx] <= wr_data;
    end
  end

  assign top_valid = (cnt_q != '0);
  assign top_addr  = mem_q[tos_q];
  assign ckpt_ptr  = tos_q;
  assign ckpt_cnt  = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Parametrised return-address stack (RAS) for the BPU; successor to the single-entry valid/data RAS record.
- Pre-IF pushes the call return address (pc+8) on B_IS_CALL predictions and pops on B_IS_RET predictions.
- Provides a snapshot (pointer, count, top) for each predicted branch; verify logic restores that snapshot on misprediction correction.
- Circular storage: on overflow the oldest entry is overwritten instead of the push being lost.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_W, 32, width of a stored return address (virt_t width).
- PTR_W, $clog2(DEPTH), top-of-stack pointer width; derived, do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  empty the stack (pipeline_flush ex/eret); stored data is retained.
- push_valid  in  1  call predicted this cycle.
- push_addr  in  ADDR_W  return address to push.
- pop_valid  in  1  return predicted this cycle.
- restore_valid  in  1  misprediction correction; reload a snapshot.
- restore_ptr  in  PTR_W  snapshot top-of-stack pointer.
- restore_cnt  in  PTR_W+1  snapshot occupancy.
- restore_data  in  ADDR_W  snapshot top entry value.
- top_valid  out  1  stack non-empty (cnt!=0).
- top_addr  out  ADDR_W  mem[tos]; predicted return target.
- ckpt_ptr  out  PTR_W  current tos, for the snapshot.
- ckpt_cnt  out  PTR_W+1  current occupancy, for the snapshot.
- overflow  out  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow  out  1  one-cycle pulse: pop attempted while empty.

Behaviour:
- State: mem[DEPTH] x ADDR_W, tos (PTR_W), cnt (0..DEPTH), overflow/underflow registers.
- Outputs are driven combinationally from registered state: top_valid=(cnt!=0), top_addr=mem[tos], ckpt_ptr=tos, ckpt_cnt=cnt. No write-to-read bypass; an action is visible on outputs the cycle after its clock edge.
- Reset: tos=0, cnt=0, mem all 0, overflow=0, underflow=0. All outputs read 0 in the cycle after reset.
- Per-edge priority: reset > flush > restore > push/pop. A lower-priority request in the same cycle is dropped entirely, with no pulses raised.
- flush: cnt<=0, tos<=0; mem is unchanged.
- restore:
  - tos<=restore_ptr; cnt<=restore_cnt, saturated to DEPTH; mem[restore_ptr]<=restore_data.
  - Only the top entry is repaired; deeper corruption is accepted.
- Push only:
  - tos<=tos+1 mod DEPTH; mem[tos+1]<=push_addr.
  - If cnt==DEPTH: cnt stays at DEPTH and overflow<=1 (oldest entry lost). Otherwise cnt<=cnt+1.
- Pop only:
  - If cnt!=0: tos<=tos-1 mod DEPTH; cnt<=cnt-1.
  - If cnt==0: tos and cnt are unchanged and underflow<=1.
  - Popped data is not cleared.
- Push and pop together (jalr ra,ra: return then call): mem[tos]<=push_addr; tos unchanged; cnt<=max(cnt,1). No pulse is raised.
- overflow and underflow are deasserted on every edge where their event does not occur.
- Wrap-around: tos moves modulo DEPTH in both directions (DEPTH-1+1 -> 0; 0-1 -> DEPTH-1).
- Reset asserted mid-sequence discards all state on that edge regardless of other inputs.

Test Plan (DEPTH=4, ADDR_W=32):
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> top_addr 0x300, ckpt_cnt 3, ckpt_ptr 3; pop twice -> top_addr 0x100, cnt 1.
- Push 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 -> overflow pulses once, in the cycle after the 5th push; cnt 4; top 0xA4; four pops yield 0xA3, 0xA2, 0xA1, then top_valid=0 (0xA0 lost).
- Pop while empty -> underflow=1 for exactly one cycle; tos=0, cnt=0 unchanged.
- From top 0x300 (cnt 3), push 0x400 and pop together -> top 0x400, cnt 3, ptr unchanged; same on empty stack -> cnt 1, top_valid=1.
- Take snapshot (ptr 2, cnt 2, top 0x200); push 0x500 and 0x600, pop once; restore the snapshot -> top 0x200, cnt 2, ptr 2; a push/pop in the restore cycle is ignored.
- With cnt 3, assert flush together with push 0x700 -> cnt 0, top_valid 0; a second test asserts reset together with restore -> all outputs 0.
